// File: rtl/bus_resp.sv
// bus_resp: CPU-side bus responder with internal RAM, six vector byte
// registers and a wait-stated external request channel.
//
// Ports:
//   clk, RST_N          clock, async active-low reset
//   AB, WE, DO          CPU address / write strobe / write data
//   DI, RDY             registered read data, CPU may advance when high
//   ext_req/we/addr/wdata  registered external request, held while waiting
//   ext_ack, ext_rdata  external completion and read data
//   bus_err             one-cycle pulse on external timeout
//
// Optional feature macro: BUS_TIMEOUT_EN enables a 4-bit EXT_WAIT timeout
// counter. Without it the responder waits forever and bus_err is tied 0.
module bus_resp #(
  parameter int          RAM_AW  = 8,
  parameter logic [15:0] RST_VEC = 16'h0200
) (
  input  logic        clk,
  input  logic        RST_N,
  input  logic [15:0] AB,
  input  logic        WE,
  input  logic [7:0]  DO,
  output logic [7:0]  DI,
  output logic        RDY,
  output logic        ext_req,
  output logic        ext_we,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_wdata,
  input  logic        ext_ack,
  input  logic [7:0]  ext_rdata,
  output logic        bus_err
);
  localparam int RAM_DEPTH = 1 << RAM_AW;

  typedef enum logic {S_IDLE = 1'b0, S_EXT_WAIT = 1'b1} state_t;
  state_t r_state, w_state_nxt;

  logic [7:0] r_ram [RAM_DEPTH];
  logic [7:0] r_vec [6];
  logic [7:0] r_di;

  logic              w_is_ram, w_is_vec, w_is_ext;
  logic [2:0]        w_vec_idx;
  logic [RAM_AW-1:0] w_ram_idx;
  logic              w_launch, w_ack, w_tmo, w_done;

  // Region decode; RAM wins if it ever overlaps the vector window.
  assign w_is_ram  = ({1'b0, AB} < 17'(RAM_DEPTH));
  assign w_is_vec  = !w_is_ram && (AB >= 16'hFFFA);
  assign w_is_ext  = !w_is_ram && !w_is_vec;
  // FFFA..FFFF have low bits 010..111, so subtracting 2 gives index 0..5.
  assign w_vec_idx = AB[2:0] - 3'd2;
  assign w_ram_idx = AB[RAM_AW-1:0];

  assign RDY      = (r_state == S_IDLE);
  assign w_launch = RDY;
  assign w_ack    = (r_state == S_EXT_WAIT) && ext_ack;
  assign w_done   = w_ack || w_tmo;
  assign DI       = r_di;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_is_ext) w_state_nxt = S_EXT_WAIT;
      S_EXT_WAIT: if (w_done)   w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // RAM keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (w_launch && WE && w_is_ram) r_ram[w_ram_idx] <= DO;
  end

  // Vector pairs are little-endian: even index holds the low byte.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 6; i++)
        r_vec[i] <= (i % 2 == 1) ? RST_VEC[15:8] : RST_VEC[7:0];
    end else if (w_launch && WE && w_is_vec) begin
      r_vec[w_vec_idx] <= DO;
    end
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N)                           r_di <= 8'h00;
    else if (w_launch && !WE && w_is_ram) r_di <= r_ram[w_ram_idx];
    else if (w_launch && !WE && w_is_vec) r_di <= r_vec[w_vec_idx];
    else if (w_ack && !ext_we)            r_di <= ext_rdata;
    else if (w_tmo && !ext_we)            r_di <= 8'hFF;
  end

  // Request fields are captured once at launch and left alone until the
  // next launch, so they stay stable for the whole wait.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      ext_req   <= 1'b0;
      ext_we    <= 1'b0;
      ext_addr  <= 16'h0000;
      ext_wdata <= 8'h00;
    end else if (w_launch && w_is_ext) begin
      ext_req   <= 1'b1;
      ext_we    <= WE;
      ext_addr  <= AB;
      ext_wdata <= DO;
    end else if (w_done) begin
      ext_req   <= 1'b0;
    end
  end

`ifdef BUS_TIMEOUT_EN
  logic [3:0] r_tmo_cnt;
  logic       r_bus_err;

  // Counter is 0 on the first EXT_WAIT edge, so a value of 14 marks the
  // 15th edge. Ack on that edge takes priority.
  assign w_tmo   = (r_state == S_EXT_WAIT) && !ext_ack && (r_tmo_cnt == 4'd14);
  assign bus_err = r_bus_err;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_tmo_cnt <= 4'd0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_tmo;
      if (w_launch && w_is_ext)       r_tmo_cnt <= 4'd0;
      else if (r_state == S_EXT_WAIT) r_tmo_cnt <= r_tmo_cnt + 4'd1;
    end
  end
`else
  assign w_tmo   = 1'b0;
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_resp.sv
// Randomized scoreboard bench for bus_resp. The driver computes expected
// read data from a simple memory model and queues it; a monitor pops and
// compares DI whenever the bus observably completes a read.
module tb_bus_resp;
  localparam int          RAM_AW  = 8;
  localparam logic [15:0] RST_VEC = 16'h0200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] AB = 16'h00FF;
  logic        WE = 1'b1;
  logic [7:0]  DO = 8'hEE;
  logic [7:0]  DI;
  logic        RDY;
  logic        ext_req, ext_we;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic        ext_ack = 1'b0;
  logic [7:0]  ext_rdata = 8'h00;
  logic        bus_err;

  bus_resp #(.RAM_AW(RAM_AW), .RST_VEC(RST_VEC)) dut (
    .clk(clk), .RST_N(rst_n), .AB(AB), .WE(WE), .DO(DO), .DI(DI), .RDY(RDY),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_ack(ext_ack), .ext_rdata(ext_rdata),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model
  logic [7:0] m_ram [256];
  logic [7:0] m_vec [6];
  logic [7:0] m_di;
  int         wr_addrs[$];
  logic [7:0] exp_q[$];

  function automatic int region(input logic [15:0] a);
    if (a < 16'(1 << RAM_AW)) return 0;
    if (a >= 16'hFFFA)        return 1;
    return 2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_vec[i] = (i % 2 == 1) ? RST_VEC[15:8] : RST_VEC[7:0];
    m_di = 8'h00;
  endtask

  task automatic set_idle();
    AB = 16'h00FF; WE = 1'b1; DO = 8'hEE;
  endtask

  // Idle cycles: harmless write to a scratch byte; random ack must be ignored.
  task automatic idle(input int n);
    set_idle();
    for (int k = 0; k < n; k++) begin
      ext_ack = 1'($urandom_range(0, 1)); ext_rdata = 8'($urandom);
      @(posedge clk); #2;
      chk("di_hold_idle", DI, m_di);
      chk("rdy_idle", RDY, 1);
    end
    ext_ack = 1'b0;
  endtask

  // One CPU access; called at a drive point (2 time units after posedge).
  task automatic acc(input logic [15:0] a, input logic w, input logic [7:0] d,
                     input int dly, input logic [7:0] rd);
    int   r, lowc, vi;
    logic tmo;
    r = region(a);
    AB = a; WE = w; DO = d;
    if (r != 2) begin
      vi = int'(a - 16'hFFFA);
      if (w) begin
        if (r == 0) begin m_ram[a[7:0]] = d; wr_addrs.push_back(int'(a[7:0])); end
        else m_vec[vi] = d;
      end else begin
        m_di = (r == 0) ? m_ram[a[7:0]] : m_vec[vi];
        exp_q.push_back(m_di);
      end
      @(posedge clk); #2;
      chk("rdy_zero_wait", RDY, 1);
    end else begin
      tmo = 1'b0; lowc = dly;
`ifdef BUS_TIMEOUT_EN
      if (dly > 15) begin tmo = 1'b1; lowc = 15; end
`endif
      if (!w) begin m_di = tmo ? 8'hFF : rd; exp_q.push_back(m_di); end
      @(posedge clk); #2;
      chk("ext_addr", ext_addr, a);
      chk("ext_we", ext_we, w);
      if (w) chk("ext_wdata", ext_wdata, d);
      for (int k = 1; k <= lowc; k++) begin
        chk("rdy_low", RDY, 0);
        chk("ext_req_hold", ext_req, 1);
        if (k == lowc && !tmo) begin ext_ack = 1'b1; ext_rdata = rd; end
        else begin ext_ack = 1'b0; ext_rdata = 8'($urandom); end
        @(posedge clk); #2;
      end
      ext_ack = 1'b0;
      chk("rdy_after_ext", RDY, 1);
      chk("ext_req_clr", ext_req, 0);
      chk("bus_err_done", bus_err, tmo);
      if (tmo) begin
        set_idle();
        @(posedge clk); #2;
        chk("bus_err_pulse_end", bus_err, 0);
      end
    end
    set_idle();
  endtask

  // Monitor: a read completes at the edge after a sample showing either an
  // idle-state RAM/VEC read, or a pending EXT read whose RDY just returned.
  initial begin
    logic        p_v, p_rdy, p_we, p_extwe;
    logic [15:0] p_ab;
    p_v = 1'b0; p_rdy = 1'b0; p_we = 1'b0; p_extwe = 1'b0; p_ab = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) p_v = 1'b0;
      else begin
        if (p_v && ((p_rdy && !p_we && region(p_ab) != 2) || (!p_rdy && RDY && !p_extwe))) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL mon_unexpected_resp: got DI=%0h want no response", DI);
          end else chk("mon_di", DI, exp_q.pop_front());
        end
        p_v = 1'b1; p_rdy = RDY; p_we = WE; p_ab = AB; p_extwe = ext_we;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int sel, n;
    logic [15:0] a;
    model_reset();
    #1;
    chk("rst_rdy", RDY, 1);
    chk("rst_ext_req", ext_req, 0);
    chk("rst_ext_we", ext_we, 0);
    chk("rst_ext_addr", ext_addr, 0);
    chk("rst_ext_wdata", ext_wdata, 0);
    chk("rst_di", DI, 0);
    chk("rst_bus_err", bus_err, 0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst_n = 1'b1;
    idle(1);

    // Vectors after reset, vector write/readback
    acc(16'hFFFC, 1'b0, 8'h00, 0, 8'h00);
    acc(16'hFFFD, 1'b0, 8'h00, 0, 8'h00);
    acc(16'hFFFC, 1'b1, 8'h34, 0, 8'h00);
    acc(16'hFFFC, 1'b0, 8'h00, 0, 8'h00);
    // RAM write then read
    acc(16'h0010, 1'b1, 8'h5A, 0, 8'h00);
    acc(16'h0010, 1'b0, 8'h00, 0, 8'h00);
    idle(1);
    // EXT read with ack in third wait cycle, then EXT write back-to-back
    acc(16'h8000, 1'b0, 8'h00, 3, 8'hC3);
    acc(16'h4000, 1'b1, 8'hA5, 1, 8'h11);
    acc(16'h0100, 1'b0, 8'h00, 1, 8'h3C);
    idle(2);

    // Reset during EXT_WAIT aborts; late ack is ignored
    AB = 16'h8123; WE = 1'b0; DO = 8'h00;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("rdy_before_abort", RDY, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_rdy", RDY, 1);
    chk("abort_ext_req", ext_req, 0);
    chk("abort_di", DI, 0);
    model_reset();
    set_idle();
    @(posedge clk); #2;
    rst_n = 1'b1;
    ext_ack = 1'b1; ext_rdata = 8'h99;
    @(posedge clk); #2;
    ext_ack = 1'b0;
    chk("late_ack_di", DI, 0);
    acc(16'hFFFD, 1'b0, 8'h00, 0, 8'h00);
    acc(16'h0010, 1'b0, 8'h00, 0, 8'h00);

`ifdef BUS_TIMEOUT_EN
    acc(16'h9000, 1'b0, 8'h00, 16, 8'h00);
    acc(16'h9001, 1'b0, 8'h00, 15, 8'h5C);
    acc(16'h9002, 1'b1, 8'h77, 17, 8'h00);
    idle(1);
`endif

    for (int it = 0; it < 300; it++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: acc(16'($urandom_range(0, 254)), 1'b1, 8'($urandom), 0, 8'h00);
        1: begin
          if (wr_addrs.size() == 0) acc(16'h0020, 1'b1, 8'($urandom), 0, 8'h00);
          else begin
            n = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
            acc(16'(n), 1'b0, 8'h00, 0, 8'h00);
          end
        end
        2: acc(16'hFFFA + 16'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
               8'($urandom), 0, 8'h00);
        3, 4: begin
          a = 16'($urandom_range(16'h0100, 16'hFFF9));
`ifdef BUS_TIMEOUT_EN
          acc(a, 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(1, 17), 8'($urandom));
`else
          acc(a, 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(1, 6), 8'($urandom));
`endif
        end
        default: idle($urandom_range(1, 3));
      endcase
    end

    idle(3);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
